// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg
//   Shared definitions for the RV64 memory-stage load/store unit:
//   - MEM_WIDTH_* access-size codes (funct3[1:0]); funct3[2]=1 marks an unsigned load
//   - LSU_STATE_* encodings and the FSM state enum built on them
//   - helpers that classify and align the byte offset of an access
//   No ports; imported by load_store_unit and mem_lane_align.
package load_store_unit_pkg;

  localparam logic [1:0] MEM_WIDTH_BYTE  = 2'b00;
  localparam logic [1:0] MEM_WIDTH_HALF  = 2'b01;
  localparam logic [1:0] MEM_WIDTH_WORD  = 2'b10;
  localparam logic [1:0] MEM_WIDTH_DWORD = 2'b11;

  localparam logic [1:0] LSU_STATE_IDLE = 2'd0;
  localparam logic [1:0] LSU_STATE_REQ  = 2'd1;
  localparam logic [1:0] LSU_STATE_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = LSU_STATE_IDLE,
    ST_REQ  = LSU_STATE_REQ,
    ST_DONE = LSU_STATE_DONE
  } lsu_state_e;

  // True when the offset is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    logic result;
    case (size)
      MEM_WIDTH_BYTE: result = 1'b0;
      MEM_WIDTH_HALF: result = off[0];
      MEM_WIDTH_WORD: result = |off[1:0];
      default:        result = |off;
    endcase
    return result;
  endfunction

  // Clears the offset bits below the access size (natural alignment).
  function automatic logic [2:0] align_offset(input logic [1:0] size, input logic [2:0] off);
    logic [2:0] result;
    case (size)
      MEM_WIDTH_BYTE: result = off;
      MEM_WIDTH_HALF: result = {off[2:1], 1'b0};
      MEM_WIDTH_WORD: result = {off[2], 2'b00};
      default:        result = 3'b000;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/load_store_unit_mem_lane_align.sv
// mem_lane_align
//   Purely combinational byte-lane steering between a 64-bit aligned data bus and
//   the pipeline's naturally sized operands.
//   Ports:
//     width      in  3   [1:0] access size, [2]=1 zero-extend loads
//     offset     in  3   byte offset inside the doubleword (already aligned)
//     store_data in  64  store operand
//     rdata      in  64  aligned doubleword read from memory
//     wstrb      out 8   byte enables for the store
//     wdata      out 64  store operand replicated across every lane of its size
//     load_data  out 64  selected lane, sign- or zero-extended
module mem_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  width,
  input  logic [2:0]  offset,
  input  logic [63:0] store_data,
  input  logic [63:0] rdata,
  output logic [7:0]  wstrb,
  output logic [63:0] wdata,
  output logic [63:0] load_data
);

  logic [63:0] lane;
  logic        is_unsigned;

  // Move the addressed byte down to bit 0 so every size extracts from the bottom.
  assign lane        = rdata >> {offset, 3'b000};
  assign is_unsigned = width[2];

  always_comb begin
    wstrb     = 8'h00;
    wdata     = 64'd0;
    load_data = 64'd0;
    case (width[1:0])
      MEM_WIDTH_BYTE: begin
        wstrb     = 8'h01 << offset;
        wdata     = {8{store_data[7:0]}};
        load_data = is_unsigned ? {56'd0, lane[7:0]} : {{56{lane[7]}}, lane[7:0]};
      end
      MEM_WIDTH_HALF: begin
        wstrb     = 8'h03 << offset;
        wdata     = {4{store_data[15:0]}};
        load_data = is_unsigned ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      end
      MEM_WIDTH_WORD: begin
        wstrb     = 8'h0F << offset;
        wdata     = {2{store_data[31:0]}};
        load_data = is_unsigned ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      end
      default: begin
        // Doubleword has no extension, so the unsigned flag is irrelevant.
        wstrb     = 8'hFF;
        wdata     = store_data;
        load_data = lane;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage access engine of the RV64 pipeline. Latches one load or store from
//   the pipeline, runs a req/ack doubleword bus cycle with byte strobes, returns the
//   extended load value and stalls the pipeline until the access retires.
//   Optional feature macro: LSU_MISALIGN_TRAP_EN
//     defined   - misaligned accesses skip the bus and retire with misalign_signal_out
//     undefined - misaligned accesses are forced to natural alignment
//   Parameter TIMEOUT_CYCLES (1..255): REQ cycles without ack before a bus error.
//   Ports:
//     clk_in, rst_n_in                     clock, synchronous active-low reset
//     mem_read_signal_in/mem_write_...     load/store request, sampled in IDLE
//     width_data_signal_in                 funct3 size/unsigned code
//     addr_in, store_data_in               effective address, store operand
//     load_data_out                        extended load result, held after done
//     stall_signal_out, done_signal_out    pipeline hold, 1-cycle retire pulse
//     bus_err_signal_out                   ack timeout, with done
//     misalign_signal_out                  misaligned trap, with done
//     dmem_req/we/addr/wdata/wstrb_out     data-memory request port
//     dmem_ack_in, dmem_rdata_in           data-memory response
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        mem_read_signal_in,
  input  logic        mem_write_signal_in,
  input  logic [2:0]  width_data_signal_in,
  input  logic [63:0] addr_in,
  input  logic [63:0] store_data_in,
  output logic [63:0] load_data_out,
  output logic        stall_signal_out,
  output logic        done_signal_out,
  output logic        bus_err_signal_out,
  output logic        misalign_signal_out,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [63:0] dmem_addr_out,
  output logic [63:0] dmem_wdata_out,
  output logic [7:0]  dmem_wstrb_out,
  input  logic        dmem_ack_in,
  input  logic [63:0] dmem_rdata_in
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state;
  lsu_state_e  next_state;

  logic [63:3] addr_q;
  logic [2:0]  width_q;
  logic [2:0]  offset_q;
  logic [63:0] store_data_q;
  logic        we_q;
  logic        req_q;
  logic        err_q;
  logic [7:0]  timeout_cnt_q;
  logic [63:0] load_data_q;

  logic        access_req;
  logic        timeout_hit;
  logic [2:0]  offset_in;
  logic [7:0]  lane_wstrb;
  logic [63:0] lane_wdata;
  logic [63:0] lane_load;

`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_in;
  logic        mis_q;
  assign misalign_in = is_misaligned(width_data_signal_in[1:0], addr_in[2:0]);
  assign offset_in   = addr_in[2:0];
`else
  assign offset_in   = align_offset(width_data_signal_in[1:0], addr_in[2:0]);
`endif

  assign access_req  = mem_read_signal_in | mem_write_signal_in;
  // Ack on the final allowed cycle still counts as success.
  assign timeout_hit = (state == ST_REQ) && !dmem_ack_in && (timeout_cnt_q == TIMEOUT_LAST);

  mem_lane_align u_lane_align (
    .width      (width_q),
    .offset     (offset_q),
    .store_data (store_data_q),
    .rdata      (dmem_rdata_in),
    .wstrb      (lane_wstrb),
    .wdata      (lane_wdata),
    .load_data  (lane_load)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state       = state;
    stall_signal_out = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access_req) begin
          stall_signal_out = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
          if (misalign_in) begin
            next_state = ST_DONE;
          end else begin
            next_state = ST_REQ;
          end
`else
          next_state = ST_REQ;
`endif
        end
      end
      ST_REQ: begin
        stall_signal_out = 1'b1;
        if (dmem_ack_in || timeout_hit) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Access latches, bus request, timeout counter and load result register.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      addr_q        <= '0;
      width_q       <= 3'd0;
      offset_q      <= 3'd0;
      store_data_q  <= 64'd0;
      we_q          <= 1'b0;
      req_q         <= 1'b0;
      err_q         <= 1'b0;
      timeout_cnt_q <= 8'd0;
      load_data_q   <= 64'd0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q         <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          err_q         <= 1'b0;
          timeout_cnt_q <= 8'd0;
`ifdef LSU_MISALIGN_TRAP_EN
          mis_q         <= 1'b0;
`endif
          if (access_req) begin
            addr_q       <= addr_in[63:3];
            width_q      <= width_data_signal_in;
            offset_q     <= offset_in;
            store_data_q <= store_data_in;
            // Read wins when both strobes are high.
            we_q         <= !mem_read_signal_in;
`ifdef LSU_MISALIGN_TRAP_EN
            if (misalign_in) begin
              mis_q       <= 1'b1;
              load_data_q <= 64'd0;
            end else begin
              req_q       <= 1'b1;
            end
`else
            req_q        <= 1'b1;
`endif
          end
        end
        ST_REQ: begin
          if (dmem_ack_in) begin
            req_q <= 1'b0;
            if (!we_q) begin
              load_data_q <= lane_load;
            end
          end else if (timeout_hit) begin
            req_q       <= 1'b0;
            err_q       <= 1'b1;
            load_data_q <= 64'd0;
          end else begin
            timeout_cnt_q <= timeout_cnt_q + 8'd1;
          end
        end
        default: begin
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign done_signal_out    = (state == ST_DONE);
  assign bus_err_signal_out = (state == ST_DONE) && err_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_signal_out = (state == ST_DONE) && mis_q;
`else
  assign misalign_signal_out = 1'b0;
`endif

  // Bus fields are only driven while a request is outstanding.
  assign load_data_out  = load_data_q;
  assign dmem_req_out   = req_q;
  assign dmem_we_out    = req_q & we_q;
  assign dmem_addr_out  = req_q ? {addr_q, 3'b000} : 64'd0;
  assign dmem_wdata_out = req_q ? lane_wdata : 64'd0;
  assign dmem_wstrb_out = (req_q && we_q) ? lane_wstrb : 8'h00;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed bench for load_store_unit. A cycle-by-cycle expectation model is written
//   by the stimulus tasks from the access rules (byte lists, size arithmetic); one
//   compare process checks every output at the falling edge. Literal checks pin the
//   model on hand-computed cases.
module tb_load_store_unit;

  localparam int TIMEOUT = 255;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        mem_read_signal_in;
  logic        mem_write_signal_in;
  logic [2:0]  width_data_signal_in;
  logic [63:0] addr_in;
  logic [63:0] store_data_in;
  logic [63:0] load_data_out;
  logic        stall_signal_out;
  logic        done_signal_out;
  logic        bus_err_signal_out;
  logic        misalign_signal_out;
  logic        dmem_req_out;
  logic        dmem_we_out;
  logic [63:0] dmem_addr_out;
  logic [63:0] dmem_wdata_out;
  logic [7:0]  dmem_wstrb_out;
  logic        dmem_ack_in;
  logic [63:0] dmem_rdata_in;

  always #5 clk_in = ~clk_in;

  load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk_in               (clk_in),
    .rst_n_in             (rst_n_in),
    .mem_read_signal_in   (mem_read_signal_in),
    .mem_write_signal_in  (mem_write_signal_in),
    .width_data_signal_in (width_data_signal_in),
    .addr_in              (addr_in),
    .store_data_in        (store_data_in),
    .load_data_out        (load_data_out),
    .stall_signal_out     (stall_signal_out),
    .done_signal_out      (done_signal_out),
    .bus_err_signal_out   (bus_err_signal_out),
    .misalign_signal_out  (misalign_signal_out),
    .dmem_req_out         (dmem_req_out),
    .dmem_we_out          (dmem_we_out),
    .dmem_addr_out        (dmem_addr_out),
    .dmem_wdata_out       (dmem_wdata_out),
    .dmem_wstrb_out       (dmem_wstrb_out),
    .dmem_ack_in          (dmem_ack_in),
    .dmem_rdata_in        (dmem_rdata_in)
  );

  int pass_count  = 0;
  int check_count = 0;

  logic        check_en = 1'b0;
  logic        exp_stall, exp_done, exp_err, exp_mis, exp_req, exp_we;
  logic [63:0] exp_addr, exp_wdata, exp_load;
  logic [7:0]  exp_wstrb;

  logic        cap_we;
  logic [63:0] cap_addr, cap_wdata;
  logic [7:0]  cap_wstrb;
  int          run_len  = 0;
  int          last_run = 0;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
  endtask

  // Reference rules, expressed per byte rather than as shifts and masks.
  function automatic int nbytes(input logic [2:0] w);
    return 1 << w[1:0];
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] w, input int a,
                                             input logic [63:0] rd);
    int n = nbytes(w);
    logic [63:0] v = 64'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(a+i) +: 8];
    if (n < 8 && !w[2] && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] model_strb(input logic [2:0] w, input int a);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < nbytes(w); i++) s[a+i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [2:0] w, input logic [63:0] d);
    logic [63:0] v = 64'd0;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = d[8*(i % nbytes(w)) +: 8];
    return v;
  endfunction

  always @(negedge clk_in) begin
    if (check_en) begin
      check_output("stall", 64'(stall_signal_out), 64'(exp_stall));
      check_output("done", 64'(done_signal_out), 64'(exp_done));
      check_output("bus_err", 64'(bus_err_signal_out), 64'(exp_err));
      check_output("misalign", 64'(misalign_signal_out), 64'(exp_mis));
      check_output("req", 64'(dmem_req_out), 64'(exp_req));
      check_output("load_data", load_data_out, exp_load);
      if (exp_req) begin
        check_output("we", 64'(dmem_we_out), 64'(exp_we));
        check_output("addr", dmem_addr_out, exp_addr);
        check_output("wstrb", 64'(dmem_wstrb_out), 64'(exp_wstrb));
        if (exp_we) check_output("wdata", dmem_wdata_out, exp_wdata);
      end
    end
    if (dmem_req_out) begin
      cap_we    = dmem_we_out;
      cap_addr  = dmem_addr_out;
      cap_wdata = dmem_wdata_out;
      cap_wstrb = dmem_wstrb_out;
      run_len++;
    end else if (run_len != 0) begin
      last_run = run_len;
      run_len  = 0;
    end
  end

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_exp();
    exp_stall = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_mis = 1'b0; exp_req = 1'b0;
  endtask

  // One access: request cycle, REQ cycles (ack after ack_delay, or never if <0), DONE, idle.
  task automatic apply_stimulus(input logic rd, input logic wr, input logic [2:0] w,
                                input logic [63:0] addr, input logic [63:0] data,
                                input logic [63:0] rdata, input int ack_delay);
    int   n, a, a_eff, reqs;
    logic timed, mis, is_wr;
    n     = nbytes(w);
    a     = int'(addr[2:0]);
    mis   = (a % n) != 0;
    a_eff = a - (a % n);
    is_wr = wr && !rd;
    timed = (ack_delay < 0) || (ack_delay >= TIMEOUT);
    reqs  = timed ? TIMEOUT : ack_delay + 1;

    next_cycle();
    mem_read_signal_in   = rd;
    mem_write_signal_in  = wr;
    width_data_signal_in = w;
    addr_in              = addr;
    store_data_in        = data;
    dmem_rdata_in        = rdata;
    clear_exp();
    exp_stall = 1'b1;

`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) begin
      next_cycle();
      mem_read_signal_in  = 1'b0;
      mem_write_signal_in = 1'b0;
      clear_exp();
      exp_done = 1'b1;
      exp_mis  = 1'b1;
      exp_load = 64'd0;
      next_cycle();
      clear_exp();
      return;
    end
`else
    if (mis) a = a_eff;
`endif

    for (int i = 0; i < reqs; i++) begin
      next_cycle();
      mem_read_signal_in  = 1'b0;
      mem_write_signal_in = 1'b0;
      clear_exp();
      exp_stall   = 1'b1;
      exp_req     = 1'b1;
      exp_we      = is_wr;
      exp_addr    = {addr[63:3], 3'b000};
      exp_wstrb   = is_wr ? model_strb(w, a_eff) : 8'h00;
      exp_wdata   = model_wdata(w, data);
      dmem_ack_in = !timed && (i == ack_delay);
    end

    next_cycle();
    dmem_ack_in = 1'b0;
    clear_exp();
    exp_done = 1'b1;
    exp_err  = timed;
    if (timed) exp_load = 64'd0;
    else if (!is_wr) exp_load = model_load(w, a_eff, rdata);

    next_cycle();
    clear_exp();
  endtask

  // Reset while a load is outstanding, then a late ack that must be ignored.
  task automatic reset_mid_access();
    next_cycle();
    mem_read_signal_in   = 1'b1;
    width_data_signal_in = 3'b011;
    addr_in              = 64'h0000_0000_0000_C000;
    clear_exp();
    exp_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      mem_read_signal_in = 1'b0;
      clear_exp();
      exp_stall = 1'b1;
      exp_req   = 1'b1;
      exp_we    = 1'b0;
      exp_addr  = 64'h0000_0000_0000_C000;
      exp_wstrb = 8'h00;
      if (i == 1) rst_n_in = 1'b0;
    end
    next_cycle();
    rst_n_in    = 1'b1;
    dmem_ack_in = 1'b1;
    clear_exp();
    exp_load = 64'd0;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      dmem_ack_in = 1'b0;
    end
  endtask

  initial begin
    rst_n_in             = 1'b0;
    mem_read_signal_in   = 1'b0;
    mem_write_signal_in  = 1'b0;
    width_data_signal_in = 3'b000;
    addr_in              = 64'd0;
    store_data_in        = 64'd0;
    dmem_ack_in          = 1'b0;
    dmem_rdata_in        = 64'd0;
    clear_exp();
    exp_we    = 1'b0;
    exp_addr  = 64'd0;
    exp_wdata = 64'd0;
    exp_wstrb = 8'h00;
    exp_load  = 64'd0;

    next_cycle();
    check_en = 1'b1;
    next_cycle();
    rst_n_in = 1'b1;
    next_cycle();

    apply_stimulus(1, 0, 3'b100, 64'h0000_0000_1000_0005, 64'd0, 64'h0000_80FF_0000_0000, 0);
    check_output("lbu_a5_literal", load_data_out, 64'h0000_0000_0000_0080);
    apply_stimulus(1, 0, 3'b100, 64'h0000_0000_1000_0004, 64'd0, 64'h0000_80FF_0000_0000, 0);
    check_output("lbu_a4_literal", load_data_out, 64'h0000_0000_0000_00FF);
    apply_stimulus(1, 0, 3'b001, 64'h0000_0000_0000_2002, 64'd0, 64'h0000_0000_8001_0000, 1);
    check_output("lh_literal", load_data_out, 64'hFFFF_FFFF_FFFF_8001);
    apply_stimulus(0, 1, 3'b010, 64'h0000_0000_0000_3004, 64'h0000_0000_1234_5678, 64'd0, 0);
    check_output("sw_wstrb_literal", 64'(cap_wstrb), 64'h0000_0000_0000_00F0);
    check_output("sw_wdata_literal", cap_wdata, 64'h1234_5678_1234_5678);
    check_output("sw_we_literal", 64'(cap_we), 64'd1);
    apply_stimulus(1, 1, 3'b000, 64'h0000_0000_0000_4007, 64'h55, 64'h8000_0000_0000_0000, 0);
    check_output("rd_wins_we_literal", 64'(cap_we), 64'd0);
    check_output("lb_literal", load_data_out, 64'hFFFF_FFFF_FFFF_FF80);
    apply_stimulus(1, 0, 3'b010, 64'h0000_0000_0000_5000, 64'd0, 64'hDEAD_BEEF_8765_4321, 5);
    check_output("ack5_req_cycles", 64'(last_run), 64'd6);
    check_output("lw_literal", load_data_out, 64'hFFFF_FFFF_8765_4321);
    apply_stimulus(1, 0, 3'b011, 64'h0000_0000_0000_6008, 64'd0, 64'h1111_2222_3333_4444, -1);
    check_output("timeout_req_cycles", 64'(last_run), 64'd255);
    check_output("timeout_load_literal", load_data_out, 64'd0);
    apply_stimulus(0, 1, 3'b011, 64'h0000_0000_0000_7003, 64'hA5A5_0000_FFFF_0001, 64'd0, 0);
`ifndef LSU_MISALIGN_TRAP_EN
    check_output("sd_mis_addr_literal", cap_addr, 64'h0000_0000_0000_7000);
    check_output("sd_mis_wstrb_literal", 64'(cap_wstrb), 64'h0000_0000_0000_00FF);
`endif
    apply_stimulus(0, 1, 3'b001, 64'h0000_0000_0000_8006, 64'h0000_0000_0000_ABCD, 64'd0, 2);
    check_output("sh_wstrb_literal", 64'(cap_wstrb), 64'h0000_0000_0000_00C0);
    check_output("sh_wdata_literal", cap_wdata, 64'hABCD_ABCD_ABCD_ABCD);
    apply_stimulus(0, 1, 3'b000, 64'h0000_0000_0000_9001, 64'h0000_0000_0000_0077, 64'd0, 0);
    check_output("sb_wstrb_literal", 64'(cap_wstrb), 64'h0000_0000_0000_0002);
    apply_stimulus(1, 0, 3'b101, 64'h0000_0000_0000_B006, 64'd0, 64'hF00D_0000_0000_0000, 0);
    check_output("lhu_literal", load_data_out, 64'h0000_0000_0000_F00D);
    apply_stimulus(1, 0, 3'b010, 64'h0000_0000_0000_B002, 64'd0, 64'h0000_0000_8000_0000, 0);
    reset_mid_access();
    check_output("reset_load_literal", load_data_out, 64'd0);
    apply_stimulus(1, 0, 3'b111, 64'h0000_0000_0000_A000, 64'd0, 64'h0123_4567_89AB_CDEF, 0);
    check_output("ld_literal", load_data_out, 64'h0123_4567_89AB_CDEF);

    next_cycle();
    check_en = 1'b0;
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
